// File: rtl/vecsum_reduce.sv
// vecsum_reduce: pipelined signed adder tree reducing LANES products to one
// saturated dot-product score per key word, with valid/ready flow control and
// a word-index counter over the sentence.
// Optional feature macro: VECSUM_REDUCE_MAX_EN adds a running per-sentence
// maximum score (out_max) and its word index (out_max_idx).
module vecsum_reduce #(
    parameter int unsigned LANES     = 64,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned NUM_WORDS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DWIDTH-1:0]      prod,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DWIDTH-1:0]            out_score,
    output logic                         out_sat,
    output logic [$clog2(NUM_WORDS)-1:0] out_idx,
    output logic                         out_last
`ifdef VECSUM_REDUCE_MAX_EN
    ,
    output logic [DWIDTH-1:0]            out_max,
    output logic [$clog2(NUM_WORDS)-1:0] out_max_idx
`endif
);

    localparam int unsigned L  = $clog2(LANES);
    localparam int unsigned SW = DWIDTH + L;
    localparam int unsigned IW = $clog2(NUM_WORDS);

    localparam logic signed [SW-1:0] SMAX    = SW'((2 ** (DWIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN    = ~SMAX;
    localparam logic [DWIDTH-1:0]    POS_SAT = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0]    NEG_SAT = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_WORDS - 1);

    logic en;
    logic out_hs;
    logic signed [DWIDTH-1:0] lane [LANES];

    logic                     out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]        score_q, score_d;
    logic                     sat_q, sat_d;
    logic [IW-1:0]            idx_q, idx_d;

    logic signed [SW-2:0]     fin_src [2];
    logic                     fin_vld;
    logic signed [SW-1:0]     sum_full;
    logic signed [SW-1:0]     shifted;

    // Global advance: the whole pipe moves unless a held output is blocked.
    always_comb begin
        en       = !out_valid_q | out_ready;
        in_ready = en & !clear;
        out_hs   = out_valid_q & out_ready;
    end

    // Unpack the lane products.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane[i] = $signed(prod[i*DWIDTH +: DWIDTH]);
        end
    end

    // Tree levels 1..L-1, each one bit wider than its source, one register each.
    for (genvar k = 1; k < L; k++) begin : g_lvl
        localparam int unsigned N = LANES >> k;
        localparam int unsigned W = DWIDTH + k;

        logic signed [W-2:0] src [2*N];
        logic                src_vld;
        logic signed [W-1:0] sum_d [N];
        logic signed [W-1:0] sum_q [N];
        logic                vld_d, vld_q;

        if (k == 1) begin : g_src
            // First level reads the accepted input vector.
            always_comb begin
                src     = lane;
                src_vld = in_valid & in_ready;
            end
        end else begin : g_src
            // Deeper levels read the previous level's registers.
            always_comb begin
                src     = g_lvl[k-1].sum_q;
                src_vld = g_lvl[k-1].vld_q;
            end
        end

        // Pairwise sums with sign extension; data only moves with a valid.
        always_comb begin
            vld_d = vld_q;
            sum_d = sum_q;
            if (clear) begin
                vld_d = 1'b0;
            end else if (en) begin
                vld_d = src_vld;
                if (src_vld) begin
                    for (int j = 0; j < N; j++) begin
                        sum_d[j] = W'(src[2*j]) + W'(src[2*j+1]);
                    end
                end
            end
        end

        // Level register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_q <= 1'b0;
                for (int j = 0; j < N; j++) begin
                    sum_q[j] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                sum_q <= sum_d;
            end
        end
    end

    if (L == 1) begin : g_fin
        // Two lanes: the final adder reads the input directly.
        always_comb begin
            fin_src = lane;
            fin_vld = in_valid & in_ready;
        end
    end else begin : g_fin
        // Final adder reads the last tree level.
        always_comb begin
            fin_src = g_lvl[L-1].sum_q;
            fin_vld = g_lvl[L-1].vld_q;
        end
    end

    // Final sum, scaling shift, saturation and output-stage next state.
    always_comb begin
        sum_full    = SW'(fin_src[0]) + SW'(fin_src[1]);
        shifted     = sum_full >>> SHIFT;
        out_valid_d = out_valid_q;
        score_d     = score_q;
        sat_d       = sat_q;
        if (clear) begin
            out_valid_d = 1'b0;
        end else if (en) begin
            out_valid_d = fin_vld;
            if (fin_vld) begin
                if (shifted > SMAX) begin
                    score_d = POS_SAT;
                    sat_d   = 1'b1;
                end else if (shifted < SMIN) begin
                    score_d = NEG_SAT;
                    sat_d   = 1'b1;
                end else begin
                    score_d = shifted[DWIDTH-1:0];
                    sat_d   = 1'b0;
                end
            end
        end
    end

    // Word index advances on each consumed score and wraps at the sentence end.
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (out_hs) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    // Output stage and word counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            score_q     <= '0;
            sat_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            score_q     <= score_d;
            sat_q       <= sat_d;
            idx_q       <= idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_score = score_q;
    assign out_sat   = sat_q;
    assign out_idx   = idx_q;
    assign out_last  = out_valid_q & (idx_q == LAST_IDX);

`ifdef VECSUM_REDUCE_MAX_EN
    logic [DWIDTH-1:0] max_q, max_d;
    logic [IW-1:0]     max_idx_q, max_idx_d;

    // Running maximum over the sentence; first occurrence wins, idx 0 re-seeds.
    always_comb begin
        max_d     = max_q;
        max_idx_d = max_idx_q;
        if (clear) begin
            max_d     = NEG_SAT;
            max_idx_d = '0;
        end else if (out_hs) begin
            if (idx_q == '0) begin
                max_d     = score_q;
                max_idx_d = '0;
            end else if ($signed(score_q) > $signed(max_q)) begin
                max_d     = score_q;
                max_idx_d = idx_q;
            end
        end
    end

    // Running maximum registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q     <= NEG_SAT;
            max_idx_q <= '0;
        end else begin
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign out_max     = max_q;
    assign out_max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_vecsum_reduce.sv
// Directed bench for vecsum_reduce (default parameters: 64 lanes x 16 bits,
// SHIFT 0, 32 words). Define VECSUM_REDUCE_MAX_EN to also cover the running max.
module tb_vecsum_reduce;

    localparam int LANES = 64;
    localparam int DW    = 16;
    localparam int NW    = 32;
    localparam int IW    = 5;

    logic                  clk;
    logic                  reset;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   prod;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_score;
    logic                  out_sat;
    logic [IW-1:0]         out_idx;
    logic                  out_last;
`ifdef VECSUM_REDUCE_MAX_EN
    logic [DW-1:0]         out_max;
    logic [IW-1:0]         out_max_idx;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vecsum_reduce #(
        .LANES     (LANES),
        .DWIDTH    (DW),
        .SHIFT     (0),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_sat   (out_sat),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef VECSUM_REDUCE_MAX_EN
        ,
        .out_max     (out_max),
        .out_max_idx (out_max_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Even lanes carry ev, odd lanes carry od.
    function automatic logic [LANES*DW-1:0] mk_alt(input logic [DW-1:0] ev, input logic [DW-1:0] od);
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*DW +: DW] = (i % 2 == 0) ? ev : od;
        end
        return v;
    endfunction

    // Only lane 0 is non-zero.
    function automatic logic [LANES*DW-1:0] mk_lane0(input logic [DW-1:0] a);
        logic [LANES*DW-1:0] v;
        v = '0;
        v[DW-1:0] = a;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int limit, output bit ok);
        int c;
        c = 0;
        while (!out_valid && c < limit) begin
            tick();
            c++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod      = '0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_score !== 16'h0000) begin n_err++; $display("FAIL reset_out_score: got %h want 0000", out_score); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
`ifdef VECSUM_REDUCE_MAX_EN
        n_cmp++; if (out_max !== 16'h8000) begin n_err++; $display("FAIL reset_out_max: got %h want 8000", out_max); end
`endif
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        int cnt;
        tick();
        prod      = mk_alt(16'h0001, 16'h0001);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        n_cmp++; if (cnt !== 6) begin n_err++; $display("FAIL lat_cycles: got %0d want 6", cnt); end
        n_cmp++; if (out_score !== 16'd64) begin n_err++; $display("FAIL lat_score: got %0d want 64", out_score); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL lat_sat: got %b want 0", out_sat); end
        n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL lat_idx: got %0d want 0", out_idx); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL lat_last: got %b want 0", out_last); end
    endtask

    task automatic test_saturation();
        logic [LANES*DW-1:0] vec [3];
        logic [DW-1:0]       exp_s [3];
        logic                exp_t [3];
        bit ok;
        vec[0] = mk_alt(16'h7FFF, 16'h7FFF); exp_s[0] = 16'h7FFF; exp_t[0] = 1'b1;
        vec[1] = mk_alt(16'h8000, 16'h8000); exp_s[1] = 16'h8000; exp_t[1] = 1'b1;
        vec[2] = mk_alt(16'h0003, 16'hFFFF); exp_s[2] = 16'd64;   exp_t[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            prod     = vec[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            wait_out(20, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL sat_timeout[%0d]: got no out_valid want out_valid", k); end
            n_cmp++; if (out_score !== exp_s[k]) begin n_err++; $display("FAIL sat_score[%0d]: got %h want %h", k, out_score, exp_s[k]); end
            n_cmp++; if (out_sat !== exp_t[k]) begin n_err++; $display("FAIL sat_flag[%0d]: got %b want %b", k, out_sat, exp_t[k]); end
            n_cmp++; if (out_idx !== IW'(k + 1)) begin n_err++; $display("FAIL sat_idx[%0d]: got %0d want %0d", k, out_idx, k + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q [$];
        logic [DW-1:0] e;
        int rec, first_c, last_c;
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear = 1'b0;
        rec = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 60; c++) begin
            in_valid = (c < 40);
            prod     = mk_alt(DW'(c + 1), DW'(c + 1));
            #1;
            if (out_valid) begin
                if (rec == 0) first_c = c;
                last_c = c;
                e = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
                n_cmp++; if (out_score !== e) begin n_err++; $display("FAIL b2b_score[%0d]: got %0d want %0d", rec, out_score, e); end
                n_cmp++; if (out_idx !== IW'(rec % NW)) begin n_err++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", rec, out_idx, rec % NW); end
                n_cmp++; if (out_last !== (rec % NW == NW - 1)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", rec, out_last, rec % NW == NW - 1); end
                rec++;
            end
            if (in_valid && in_ready) q.push_back(DW'(64 * (c + 1)));
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (rec !== 40) begin n_err++; $display("FAIL b2b_count: got %0d want 40", rec); end
        n_cmp++; if (first_c !== 6) begin n_err++; $display("FAIL b2b_first: got %0d want 6", first_c); end
        n_cmp++; if (last_c - first_c !== 39) begin n_err++; $display("FAIL b2b_span: got %0d want 39", last_c - first_c); end
        n_cmp++; if (out_idx !== 5'd8) begin n_err++; $display("FAIL b2b_final_idx: got %0d want 8", out_idx); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] q [$];
        logic [DW-1:0] e;
        int sent, rec, c;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sent = 0; rec = 0; c = 0;
        while (rec < 30 && c < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 30);
            prod      = mk_alt(DW'(sent + 10), DW'(sent + 10));
            #1;
            n_cmp++; if (in_ready !== (!out_valid | out_ready)) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want %b", c, in_ready, !out_valid | out_ready); end
            if (out_valid && out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
                n_cmp++; if (out_score !== e) begin n_err++; $display("FAIL stall_score[%0d]: got %0d want %0d", rec, out_score, e); end
                n_cmp++; if (out_idx !== IW'(rec % NW)) begin n_err++; $display("FAIL stall_idx[%0d]: got %0d want %0d", rec, out_idx, rec % NW); end
                rec++;
            end
            if (in_valid && in_ready) begin
                q.push_back(DW'(64 * (sent + 10)));
                sent++;
            end
            tick();
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (rec !== 30) begin n_err++; $display("FAIL stall_count: got %0d want 30", rec); end
    endtask

    task automatic test_clear();
        int seen;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prod     = mk_alt(DW'(7 + i), DW'(7 + i));
            in_valid = 1'b1;
            tick();
        end
        clear = 1'b1;
        prod  = mk_alt(16'd11, 16'd11);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL clear_idx: got %0d want 0", out_idx); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL clear_flushed: got %0d outputs want 0", seen); end
        prod     = mk_alt(16'd5, 16'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(20, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL clear_timeout: got no out_valid want out_valid"); end
        n_cmp++; if (out_score !== 16'd320) begin n_err++; $display("FAIL clear_next_score: got %0d want 320", out_score); end
        n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL clear_next_idx: got %0d want 0", out_idx); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        prod      = mk_alt(16'h7FFF, 16'h7FFF);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(20, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmid_timeout: got no out_valid want out_valid"); end
        n_cmp++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL rmid_pre_sat: got %b want 1", out_sat); end
        n_cmp++; if (out_idx !== 5'd1) begin n_err++; $display("FAIL rmid_pre_idx: got %0d want 1", out_idx); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_score !== 16'h0000) begin n_err++; $display("FAIL rmid_out_score: got %h want 0000", out_score); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL rmid_out_sat: got %b want 0", out_sat); end
        n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL rmid_out_idx: got %0d want 0", out_idx); end
        #2;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef VECSUM_REDUCE_MAX_EN
    task automatic test_max();
        int sent, rec, c;
        logic [DW-1:0] v;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        out_ready = 1'b1;
        sent = 0; rec = 0; c = 0;
        while (rec < 32 && c < 100) begin
            case (sent)
                7, 20:   v = 16'd500;
                3:       v = 16'hFF9C;
                31:      v = 16'd499;
                default: v = DW'(sent);
            endcase
            in_valid = (sent < 32);
            prod     = mk_lane0(v);
            #1;
            if (out_valid) rec++;
            if (in_valid && in_ready) sent++;
            tick();
            c++;
        end
        in_valid = 1'b0;
        n_cmp++; if (rec !== 32) begin n_err++; $display("FAIL max_count: got %0d want 32", rec); end
        n_cmp++; if (out_max !== 16'd500) begin n_err++; $display("FAIL max_value: got %0d want 500", out_max); end
        n_cmp++; if (out_max_idx !== 5'd7) begin n_err++; $display("FAIL max_idx: got %0d want 7", out_max_idx); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_clear();
        test_reset_mid();
`ifdef VECSUM_REDUCE_MAX_EN
        test_max();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vecsum_reduce.md
Name: vecsum_reduce

Overview:
- Pipelined signed adder tree that reduces the 64 lane products from the vector-matrix multiplier stage to one dot-product score per key word.
- Sits directly downstream of the multiplier stage and upstream of the score RAM / softmax logic.
- Adds a valid/ready handshake, a word-index counter over the sentence, and saturation to DATA_WIDTH.

Parameters:
- LANES, 64, number of product lanes; power of two, at least 2.
- DWIDTH, 16, signed two's-complement width of each product and of the score.
- SHIFT, 0, arithmetic right shift applied to the full-width sum before saturation (0..6).
- NUM_WORDS, 32, words per sentence; sets the wrap point of out_idx.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of the pipeline and word counter
- in_valid  in  1  prod is valid
- in_ready  out  1  stage accepts prod this cycle
- prod  in  LANES*DWIDTH  lane i at [i*DWIDTH +: DWIDTH], signed
- out_valid  out  1  score valid
- out_ready  in  1  consumer accepts score
- out_score  out  DWIDTH  saturated, shifted signed sum
- out_sat  out  1  out_score was clamped
- out_idx  out  $clog2(NUM_WORDS)  word index of out_score
- out_last  out  1  out_idx == NUM_WORDS-1

Behaviour:
- Tree depth L = log2(LANES), 6 by default. One register stage per tree level, each carrying a valid bit. Level k sums are DWIDTH+k bits, sign-extended, with no internal overflow. The final sum is DWIDTH+L bits (22 by default).
- Global advance: en = !out_valid | out_ready. in_ready = en. A transfer occurs when in_valid & in_ready. When en=0, every stage, valid bit and output holds.
- Latency: a transfer in cycle t produces out_valid=1 in cycle t+L when no stall occurs. Throughput is one vector per cycle.
- Output stage, registered with the last tree level:
  - s = full sum >>> SHIFT (arithmetic).
  - If s > 2^(DWIDTH-1)-1, out_score = 0x7FFF and out_sat = 1.
  - If s < -2^(DWIDTH-1), out_score = 0x8000 and out_sat = 1.
  - Otherwise out_score = s[DWIDTH-1:0] and out_sat = 0.
- Word counter:
  - Increments on each output handshake (out_valid & out_ready). out_idx/out_last reflect the current output.
  - After index NUM_WORDS-1 is consumed, it wraps to 0.
  - out_last is combinational from out_idx and is qualified by out_valid.
- Reset (async, active-low): all stage valids, out_valid, out_sat, out_score, out_idx and out_last go to 0. Tree data registers may also be cleared to 0.
- clear=1 at a clock edge:
  - Clears all valid bits and out_idx to 0. Any in-flight data is discarded.
  - In that cycle in_ready is forced to 0, so no input is accepted.
  - clear takes priority over a simultaneous handshake.
- Simultaneous output handshake and input acceptance in the same cycle is legal; the pipeline shifts with no bubble.
- out_score and out_sat are undefined-but-stable (held) while out_valid=0; benches check them only when out_valid=1.

Optional Feature:
- Macro: VECSUM_REDUCE_MAX_EN.
- When defined, adds the ports out_max (DWIDTH, out) and out_max_idx ($clog2(NUM_WORDS), out).
- A running maximum of the saturated out_score values and its index are tracked over the current sentence:
  - Updated on each output handshake, using strict greater-than, so the first occurrence wins.
  - Re-seeded with the handshaked score at idx 0.
  - Cleared to 0x8000 / 0 by reset and by clear.
- out_max and out_max_idx are registered and valid in the cycle after the out_last handshake; they hold until the next sentence's idx-0 handshake.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, all lanes 0x0001, in_valid one cycle, out_ready=1 -> out_valid exactly 6 cycles later, out_score=64, out_sat=0, out_idx=0.
- All lanes 0x7FFF (sum 2097088) -> out_score=0x7FFF, out_sat=1. All lanes 0x8000 (sum -2097152) -> out_score=0x8000, out_sat=1. Lanes alternating +3/-1 -> out_score=64, out_sat=0.
- Back-to-back input for 40 cycles, out_ready=1 -> 40 consecutive scores. out_idx runs 0..31 then 0..7. out_last=1 only at idx 31.
- Stream with out_ready toggling 0/1 randomly -> no loss or duplication, in_ready==(!out_valid|out_ready), score order preserved.
- clear asserted with 3 vectors in flight -> no out_valid for those vectors, next output has out_idx=0. Reset asserted mid-stream -> outputs 0 immediately, without a clock edge.
- With VECSUM_REDUCE_MAX_EN: 32 scores where the maximum 500 occurs at idx 7 and again at idx 20 -> after the idx-31 handshake, out_max=500 and out_max_idx=7.
